shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width; only 16 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; it SHALL be asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, which requests an operation.
REQ-005 The block SHALL have port op, input, 2 bits, the operation code: 00 ROR, 01 ASR, 10 LSR, 11 LSL.
REQ-006 The block SHALL have port amt, input, 4 bits, the shift count 0..15.
REQ-007 The block SHALL have port a, input, 16 bits, the operand.
REQ-008 The block SHALL have port y, output, 16 bits, the registered result.
REQ-009 The block SHALL have port busy, output, 1 bit, high while the block is in state SHIFT.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking y valid.
REQ-011 The block SHALL have port carry, output, 1 bit, present only when SHIFT_CARRY_EN is defined.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE, with state register, 16-bit working register and 4-bit down-counter.
REQ-013 start SHALL be accepted only in IDLE or DONE (busy=0); at an accepting edge the block SHALL load a, op and amt; the next state SHALL be SHIFT if amt!=0, else DONE.
REQ-014 Each cycle in SHIFT SHALL apply exactly one 1-bit step per op.
- ROR: y={y[0],y[15:1]}
- ASR: {y[15],y[15:1]}
- LSR: {1'b0,y[15:1]}
- LSL: {y[14:0],1'b0}
REQ-015 In SHIFT, the counter SHALL decrement per step; the step that takes it to 0 SHALL move the state to DONE.
REQ-016 For start sampled at edge t, done SHALL be high for exactly one cycle after edge t+amt, with y equal to the fully shifted result (latency amt+1 cycles; amt=0 gives y=a after 1 cycle).
REQ-017 From DONE, the block SHALL go to IDLE unless start=1, in which case a new operation SHALL load, allowing back-to-back operations with no idle cycle.
REQ-018 start while busy=1 SHALL be ignored: no reload, no change to op, amt or remaining count.
REQ-019 y SHALL hold its last result in IDLE until the next accepted start; inputs a, op and amt SHALL be don't-care outside accepting edges.
REQ-020 done and busy SHALL never be high in the same cycle.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, y=0, counter=0, busy=0, done=0 and carry=0, including mid-operation; the aborted result SHALL be discarded and no done SHALL be issued.
REQ-022 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-023 With macro SHIFT_CARRY_EN defined, port carry SHALL exist and hold the last bit shifted out (ROR/ASR/LSR: y[0] before the final step; LSL: y[15] before the final step); carry SHALL be cleared on every accepted start, so amt=0 leaves carry=0, and SHALL be valid with done and held until the next start.
REQ-024 Without SHIFT_CARRY_EN, port carry and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL apply op=ROR, a=0x0001, amt=1, start at t and require done at t+2 with y=0x8000, and carry=1 if SHIFT_CARRY_EN.
REQ-026 The bench SHALL apply op=ASR, a=0x8000, amt=4 and require busy for 4 cycles, then done with y=0xF800; it SHALL repeat with op=ROR, a=0x1234, amt=4 and require y=0x4123.
REQ-027 The bench SHALL apply op=LSL, a=0xFFFF, amt=15 and require y=0x8000 at t+16, with carry=1 if SHIFT_CARRY_EN.
REQ-028 The bench SHALL apply amt=0, a=0xBEEF and require done at t+1, y=0xBEEF, busy never high and carry=0; it SHALL then apply start in the done cycle with op=LSR, a=0x0010, amt=4 and require y=0x0001 four cycles later.
REQ-029 The bench SHALL pulse start with a=0x0000 during busy and require the first result unchanged; it SHALL assert rst mid-SHIFT and require y=0, busy=0 and no done pulse.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: performs ROR/ASR/LSR/LSL one bit per clock, amt steps per operation.
// Optional macro SHIFT_CARRY_EN adds the 'carry' output holding the last bit shifted out.
module shift_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [3:0]       amt,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done
`ifdef SHIFT_CARRY_EN
   ,
   output logic             carry
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } stateT;

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_ASR = 2'b01;
   localparam logic [1:0] OP_LSR = 2'b10;
   localparam logic [1:0] OP_LSL = 2'b11;

   stateT            state;
   stateT            nextState;
   logic [WIDTH-1:0] workReg;
   logic [WIDTH-1:0] stepVal;
   logic [1:0]       opReg;
   logic [3:0]       count;
   logic             accept;

   // A new operation may only be taken when no shift is in flight.
   assign accept = start && (state != SHIFT);
   assign y      = workReg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               nextState = (amt != 4'd0) ? SHIFT : DONE;
            end else begin
               nextState = IDLE;
            end
         end
         SHIFT: begin
            if (count == 4'd1) begin
               nextState = DONE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   always_comb begin
      stepVal = workReg;
      case (opReg)
         OP_ROR:  stepVal = {workReg[0], workReg[WIDTH-1:1]};
         OP_ASR:  stepVal = {workReg[WIDTH-1], workReg[WIDTH-1:1]};
         OP_LSR:  stepVal = {1'b0, workReg[WIDTH-1:1]};
         OP_LSL:  stepVal = {workReg[WIDTH-2:0], 1'b0};
         default: stepVal = workReg;
      endcase
   end

   // The result register doubles as the working register; it holds its value outside SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         workReg <= '0;
         opReg   <= OP_ROR;
         count   <= 4'd0;
      end else if (accept) begin
         workReg <= a;
         opReg   <= op;
         count   <= amt;
      end else if (state == SHIFT) begin
         workReg <= stepVal;
         count   <= count - 4'd1;
      end
   end

`ifdef SHIFT_CARRY_EN
   logic outBit;

   always_comb begin
      outBit = (opReg == OP_LSL) ? workReg[WIDTH-1] : workReg[0];
   end

   // Cleared on every accepted start so a zero-length shift reports no carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry <= 1'b0;
      end else if (accept) begin
         carry <= 1'b0;
      end else if (state == SHIFT) begin
         carry <= outBit;
      end
   end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results. Honours SHIFT_CARRY_EN if defined.
module tb_shift_sequencer;

   localparam logic [1:0] ROR = 2'b00;
   localparam logic [1:0] ASR = 2'b01;
   localparam logic [1:0] LSR = 2'b10;
   localparam logic [1:0] LSL = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  amt;
   logic [15:0] a;
   logic [15:0] y;
   logic        busy;
   logic        done;
`ifdef SHIFT_CARRY_EN
   logic        carry;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .amt   (amt),
      .a     (a),
      .y     (y),
      .busy  (busy),
      .done  (done)
`ifdef SHIFT_CARRY_EN
      ,
      .carry (carry)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference result of shifting x by n places in one go.
   function automatic logic [15:0] refResult(input logic [1:0] o, input logic [15:0] x, input int n);
      logic [15:0] r;
      case (o)
         ROR:     r = (n == 0) ? x : ((x >> n) | (x << (16 - n)));
         ASR:     r = 16'($signed(x) >>> n);
         LSR:     r = x >> n;
         default: r = x << n;
      endcase
      return r;
   endfunction

   // Last bit to leave the word after n single-bit steps.
   function automatic logic refCarry(input logic [1:0] o, input logic [15:0] x, input int n);
      if (n == 0) return 1'b0;
      if (o == LSL) return x[16 - n];
      return x[n - 1];
   endfunction

   logic        sStart;
   logic [1:0]  sOp;
   logic [3:0]  sAmt;
   logic [15:0] sA;

   always @(posedge clk) begin
      sStart <= start;
      sOp    <= op;
      sAmt   <= amt;
      sA     <= a;
   end

   int          mBusyLeft = 0;
   logic        mDone     = 1'b0;
   logic [15:0] mY        = 16'h0;
   logic        mCarry    = 1'b0;
   logic [15:0] pendY     = 16'h0;
   logic        pendC     = 1'b0;

   always @(negedge clk) begin
      logic acc;
      logic newDone;
      if (rst) begin
         mBusyLeft = 0;
         mDone     = 1'b0;
         mY        = 16'h0;
         mCarry    = 1'b0;
      end else begin
         acc     = sStart && (mBusyLeft == 0);
         newDone = 1'b0;
         if (mBusyLeft > 0) begin
            mBusyLeft--;
            if (mBusyLeft == 0) begin
               newDone = 1'b1;
               mY      = pendY;
               mCarry  = pendC;
            end
         end
         if (acc) begin
            pendY  = refResult(sOp, sA, int'(sAmt));
            pendC  = refCarry(sOp, sA, int'(sAmt));
            mCarry = 1'b0;
            if (sAmt == 4'd0) begin
               newDone = 1'b1;
               mY      = sA;
            end else begin
               mBusyLeft = int'(sAmt);
            end
         end
         mDone = newDone;
      end
      check("model busy", 32'(busy), 32'(mBusyLeft > 0));
      check("model done", 32'(done), 32'(mDone));
      if (mBusyLeft == 0) begin
         check("model y", 32'(y), 32'(mY));
`ifdef SHIFT_CARRY_EN
         check("model carry", 32'(carry), 32'(mCarry));
`endif
      end
   end

   task automatic applyStimulus(input logic [1:0] o, input logic [15:0] av, input logic [3:0] m);
      start = 1'b1;
      op    = o;
      a     = av;
      amt   = m;
   endtask

   // Waits for done after a start; pokeAt injects a junk start on that cycle (0 = never).
   task automatic checkOutput(input string name, input logic [15:0] expY, input logic expCarry,
                              input int expLat, input int expBusy, input int pokeAt);
      int   cyc     = 0;
      int   busyCnt = 0;
      logic seen    = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         #1;
         cyc++;
         if (cyc == pokeAt) begin
            start = 1'b1;
            a     = 16'h0000;
            op    = LSL;
            amt   = 4'd1;
         end else begin
            start = 1'b0;
            a     = 16'($urandom);
            op    = 2'($urandom);
            amt   = 4'($urandom);
         end
         if (busy) busyCnt++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: no done within %0d cycles", name, cyc);
      end else begin
         check({name, " latency"}, 32'(cyc), 32'(expLat));
         check({name, " y"}, 32'(y), 32'(expY));
         check({name, " busy cycles"}, 32'(busyCnt), 32'(expBusy));
`ifdef SHIFT_CARRY_EN
         check({name, " carry"}, 32'(carry), 32'(expCarry));
`else
         if (expCarry === 1'bx) $display("[TB] unexpected carry expectation");
`endif
      end
   endtask

   initial begin
      int doneCnt;
      rst   = 1'b1;
      start = 1'b0;
      op    = ROR;
      amt   = 4'd0;
      a     = 16'h0;
      repeat (2) @(negedge clk);
      #1;
      check("reset y", 32'(y), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      rst = 1'b0;

      $display("[TB] ROR by 1 immediately after reset");
      applyStimulus(ROR, 16'h0001, 4'd1);
      checkOutput("ror1", 16'h8000, 1'b1, 2, 1, 0);

      @(negedge clk); #1;
      applyStimulus(ASR, 16'h8000, 4'd4);
      checkOutput("asr4", 16'hF800, 1'b0, 5, 4, 0);

      @(negedge clk); #1;
      applyStimulus(ROR, 16'h1234, 4'd4);
      checkOutput("ror4", 16'h4123, 1'b0, 5, 4, 0);

      @(negedge clk); #1;
      applyStimulus(LSL, 16'hFFFF, 4'd15);
      checkOutput("lsl15", 16'h8000, 1'b1, 16, 15, 0);

      $display("[TB] zero shift then back-to-back LSR");
      @(negedge clk); #1;
      applyStimulus(ROR, 16'hBEEF, 4'd0);
      checkOutput("amt0", 16'hBEEF, 1'b0, 1, 0, 0);
      applyStimulus(LSR, 16'h0010, 4'd4);
      checkOutput("b2b lsr4", 16'h0001, 1'b0, 5, 4, 0);

      repeat (3) @(negedge clk);
      #1;
      check("idle hold y", 32'(y), 32'h0001);

      $display("[TB] start pulsed while busy");
      applyStimulus(ROR, 16'h1234, 4'd4);
      checkOutput("ignore busy start", 16'h4123, 1'b0, 5, 4, 2);

      $display("[TB] reset during SHIFT");
      @(negedge clk); #1;
      applyStimulus(LSL, 16'hFFFF, 4'd8);
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      check("pre-abort busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      check("abort y", 32'(y), 32'h0);
      check("abort busy", 32'(busy), 32'h0);
      check("abort done", 32'(done), 32'h0);
`ifdef SHIFT_CARRY_EN
      check("abort carry", 32'(carry), 32'h0);
`endif
      doneCnt = 0;
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk); #1;
         if (done) doneCnt++;
      end
      check("abort no done", 32'(doneCnt), 32'h0);

      applyStimulus(LSL, 16'h00A5, 4'd0);
      checkOutput("post-abort amt0", 16'h00A5, 1'b0, 1, 0, 0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
